mem_ls_stage: RTL and testbench

MEM_LS_STAGE -- requirements
Module: mem_ls_stage

---
 rtl/mem_ls_stage.sv | 178 +++++++++++++++++
 tb/tb_mem_ls_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ls_stage.sv
// rtl/mem_ls_stage.sv - pipeline memory stage: load/store issue over a req/addr_ok/data_ok SRAM port
// Optional misaligned h/w access trap when MEM_ALIGN_CHECK_EN is defined (adds ms_ale).
module mem_ls_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int          RF_WE_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               ds_valid,
    output logic               ms_allow_in,
    input  logic [31:0]        ds_pc,
    input  logic [3:0]         ds_mem_op,
    input  logic [31:0]        ds_addr,
    input  logic [31:0]        ds_st_data,
    input  logic [RF_WE_W-1:0] ds_rf_we,
    input  logic [4:0]         ds_rf_waddr,
    input  logic [31:0]        ds_rf_wdata,
    output logic               data_sram_req,
    output logic [3:0]         data_sram_wstrb,
    output logic [31:0]        data_sram_addr,
    output logic [31:0]        data_sram_wdata,
    input  logic               data_sram_addr_ok,
    input  logic               data_sram_data_ok,
    input  logic [31:0]        data_sram_rdata,
    input  logic               wb_allow_in,
    output logic               ms_to_ws_valid,
    output logic [31:0]        ms_pc,
    output logic [RF_WE_W-1:0] ms_rf_we,
    output logic [4:0]         ms_rf_waddr,
    output logic [31:0]        ms_rf_wdata
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic               ms_ale
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_CANCEL} state_t;
    state_t state;

    logic        is_load, is_store, accept, misalign;
    logic [3:0]  st_strb;
    logic [31:0] st_wdata, ld_shift, ld_result;
    logic        ld_pend, ld_uns;
    logic [1:0]  ld_size, ld_off;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        case (ds_mem_op)
            4'b0001, 4'b0010, 4'b0011, 4'b1001, 4'b1010: is_load  = 1'b1;
            4'b0100, 4'b0101, 4'b0110:                   is_store = 1'b1;
            default: ;
        endcase
    end

    // Store op low bits: 00 byte, 01 half, 10 word
    always_comb begin
        st_strb  = 4'b0000;
        st_wdata = ds_st_data;
        if (is_store) begin
            case (ds_mem_op[1:0])
                2'b00: begin
                    st_strb  = 4'b0001 << ds_addr[1:0];
                    st_wdata = {4{ds_st_data[7:0]}};
                end
                2'b01: begin
                    st_strb  = ds_addr[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{ds_st_data[15:0]}};
                end
                default: st_strb = 4'b1111;
            endcase
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic size_h, size_w, ale_q;
    assign size_h   = is_load ? (ds_mem_op[1:0] == 2'b10) : (ds_mem_op[1:0] == 2'b01);
    assign size_w   = is_load ? (ds_mem_op[1:0] == 2'b11) : (ds_mem_op[1:0] == 2'b10);
    assign misalign = (is_load || is_store) &&
                      ((size_h && ds_addr[0]) || (size_w && (ds_addr[1:0] != 2'b00)));
    assign ms_ale   = ale_q && (state == S_DONE);
`else
    assign misalign = 1'b0;
`endif

    // Load op low bits: 01 byte, 10 half, 11 word; op[3] selects zero-extension
    assign ld_shift = data_sram_rdata >> {ld_off, 3'b000};
    always_comb begin
        case (ld_size)
            2'b01:   ld_result = ld_uns ? {24'd0, ld_shift[7:0]}  : {{24{ld_shift[7]}}, ld_shift[7:0]};
            2'b10:   ld_result = ld_uns ? {16'd0, ld_shift[15:0]} : {{16{ld_shift[15]}}, ld_shift[15:0]};
            default: ld_result = ld_shift;
        endcase
    end

    assign ms_allow_in     = (state == S_IDLE) || ((state == S_DONE) && wb_allow_in);
    assign accept          = ds_valid && ms_allow_in && !flush;
    assign data_sram_req   = (state == S_REQ);
    assign ms_to_ws_valid  = (state == S_DONE);
    assign data_sram_addr  = req_addr;
    assign data_sram_wstrb = req_wstrb;
    assign data_sram_wdata = req_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            ms_pc       <= RESET_PC;
            ms_rf_we    <= '0;
            ms_rf_waddr <= 5'd0;
            ms_rf_wdata <= 32'd0;
            ld_pend     <= 1'b0;
            ld_uns      <= 1'b0;
            ld_size     <= 2'b00;
            ld_off      <= 2'b00;
            req_addr    <= 32'd0;
            req_wstrb   <= 4'd0;
            req_wdata   <= 32'd0;
`ifdef MEM_ALIGN_CHECK_EN
            ale_q       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (accept) begin
                        ms_pc       <= ds_pc;
                        ms_rf_waddr <= ds_rf_waddr;
                        ms_rf_wdata <= ds_rf_wdata;
                        ms_rf_we    <= (is_store || misalign) ? '0 : ds_rf_we;
                        ld_pend     <= is_load;
                        ld_uns      <= ds_mem_op[3];
                        ld_size     <= ds_mem_op[1:0];
                        ld_off      <= ds_addr[1:0];
                        req_addr    <= ds_addr;
                        req_wstrb   <= st_strb;
                        req_wdata   <= st_wdata;
`ifdef MEM_ALIGN_CHECK_EN
                        ale_q       <= misalign;
`endif
                        state <= ((is_load || is_store) && !misalign) ? S_REQ : S_DONE;
                    end else if ((state == S_DONE) && wb_allow_in) begin
                        state <= S_IDLE;
                    end
                end
                S_REQ: begin
                    // An accepted request still owes a data_ok, so a flush must swallow it
                    if (flush) begin
                        state <= (data_sram_addr_ok && !data_sram_data_ok) ? S_CANCEL : S_IDLE;
                    end else if (data_sram_addr_ok) begin
                        if (data_sram_data_ok) begin
                            state <= S_DONE;
                            if (ld_pend) ms_rf_wdata <= ld_result;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (data_sram_data_ok) begin
                        state <= flush ? S_IDLE : S_DONE;
                        if (!flush && ld_pend) ms_rf_wdata <= ld_result;
                    end else if (flush) begin
                        state <= S_CANCEL;
                    end
                end
                S_CANCEL: begin
                    if (data_sram_data_ok) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ls_stage.sv
// tb/tb_mem_ls_stage.sv - directed bench for mem_ls_stage with a transaction-level expectation model
module tb_mem_ls_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, ds_valid, ms_allow_in;
    logic [31:0] ds_pc, ds_addr, ds_st_data, ds_rf_wdata;
    logic [3:0]  ds_mem_op, ds_rf_we;
    logic [4:0]  ds_rf_waddr;
    logic        data_sram_req, data_sram_addr_ok, data_sram_data_ok;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic        wb_allow_in, ms_to_ws_valid;
    logic [31:0] ms_pc, ms_rf_wdata;
    logic [3:0]  ms_rf_we;
    logic [4:0]  ms_rf_waddr;
`ifdef MEM_ALIGN_CHECK_EN
    logic        ms_ale;
    logic        exp_ale, p_ale;
`endif

    mem_ls_stage dut (
        .clk(clk), .reset(reset), .flush(flush), .ds_valid(ds_valid), .ms_allow_in(ms_allow_in),
        .ds_pc(ds_pc), .ds_mem_op(ds_mem_op), .ds_addr(ds_addr), .ds_st_data(ds_st_data),
        .ds_rf_we(ds_rf_we), .ds_rf_waddr(ds_rf_waddr), .ds_rf_wdata(ds_rf_wdata),
        .data_sram_req(data_sram_req), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .wb_allow_in(wb_allow_in),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_rf_we(ms_rf_we),
        .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata)
`ifdef MEM_ALIGN_CHECK_EN
        , .ms_ale(ms_ale)
`endif
    );

    int nvec = 0, nerr = 0;
    logic chk_en = 1'b0;
    logic exp_allow, exp_req, exp_valid, exp_rst, exp_chk_wd;
    logic [31:0] exp_addr, exp_strb, exp_wd, exp_pc, exp_we, exp_wa, exp_rf;
    logic [31:0] p_pc, p_we, p_wa, p_rf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("allow_in", {31'd0, ms_allow_in}, {31'd0, exp_allow});
            chk("ws_valid", {31'd0, ms_to_ws_valid}, {31'd0, exp_valid});
            chk("sram_req", {31'd0, data_sram_req}, {31'd0, exp_req});
            if (exp_req) begin
                chk("sram_addr", data_sram_addr, exp_addr);
                chk("sram_wstrb", {28'd0, data_sram_wstrb}, exp_strb);
                if (exp_chk_wd) chk("sram_wdata", data_sram_wdata, exp_wd);
            end
            if (exp_valid || exp_rst) begin
                chk("ms_pc", ms_pc, exp_pc);
                chk("ms_rf_we", {28'd0, ms_rf_we}, exp_we);
                chk("ms_rf_waddr", {27'd0, ms_rf_waddr}, exp_wa);
                chk("ms_rf_wdata", ms_rf_wdata, exp_rf);
            end
`ifdef MEM_ALIGN_CHECK_EN
            chk("ms_ale", {31'd0, ms_ale}, {31'd0, exp_valid && exp_ale});
`endif
        end
    end

    function automatic bit is_ld(input logic [3:0] op);
        return op == 4'd1 || op == 4'd2 || op == 4'd3 || op == 4'd9 || op == 4'd10;
    endfunction
    function automatic bit is_st(input logic [3:0] op);
        return op == 4'd4 || op == 4'd5 || op == 4'd6;
    endfunction
    function automatic logic [31:0] m_strb(input logic [3:0] op, input logic [31:0] addr);
        int off = int'(addr % 4);
        if (op == 4'd4) return 32'(1 << off);
        if (op == 4'd5) return (off >= 2) ? 32'd12 : 32'd3;
        if (op == 4'd6) return 32'd15;
        return 32'd0;
    endfunction
    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] st);
        if (op == 4'd4) return (st & 32'hff) * 32'h01010101;
        if (op == 4'd5) return (st & 32'hffff) * 32'h00010001;
        return st;
    endfunction
    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        logic [31:0] v = rdata >> (8 * (addr % 4));
        case (op)
            4'd1:  begin v = v % 256;   if (v >= 128)   v = v | 32'hffffff00; end
            4'd9:  v = v % 256;
            4'd2:  begin v = v % 65536; if (v >= 32768) v = v | 32'hffff0000; end
            4'd10: v = v % 65536;
            default: v = rdata;
        endcase
        return v;
    endfunction
`ifdef MEM_ALIGN_CHECK_EN
    function automatic bit m_misalign(input logic [3:0] op, input logic [31:0] addr);
        if (op == 4'd2 || op == 4'd10 || op == 4'd5) return (addr % 2) != 0;
        if (op == 4'd3 || op == 4'd6) return (addr % 4) != 0;
        return 1'b0;
    endfunction
`endif

    // One clock: drive inputs, expectations for this cycle; result fields follow the last accepted op
    task automatic cyc(input bit dv, input bit aok, input bit dok, input bit wb, input bit fl,
                       input bit ea, input bit er, input bit ev);
        @(posedge clk); #1;
        ds_valid = dv; data_sram_addr_ok = aok; data_sram_data_ok = dok;
        wb_allow_in = wb; flush = fl;
        exp_allow = ea; exp_req = er; exp_valid = ev;
        exp_pc = p_pc; exp_we = p_we; exp_wa = p_wa; exp_rf = p_rf;
`ifdef MEM_ALIGN_CHECK_EN
        exp_ale = p_ale;
`endif
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] st,
                         input logic [3:0] we, input logic [4:0] wa, input logic [31:0] alu,
                         input logic [31:0] pc, input logic [31:0] rdata, output bit mem);
        bit mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = m_misalign(op, addr);
        p_ale = mis;
`endif
        mem = (is_ld(op) || is_st(op)) && !mis;
        ds_pc = pc; ds_mem_op = op; ds_addr = addr; ds_st_data = st;
        ds_rf_we = we; ds_rf_waddr = wa; ds_rf_wdata = alu; data_sram_rdata = rdata;
        exp_addr = addr; exp_strb = m_strb(op, addr); exp_wd = m_wdata(op, st); exp_chk_wd = is_st(op);
        p_pc = pc; p_wa = {27'd0, wa};
        p_we = (is_st(op) || mis) ? 32'd0 : {28'd0, we};
        p_rf = (is_ld(op) && !mis) ? m_load(op, addr, rdata) : alu;
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] st,
                       input logic [3:0] we, input logic [4:0] wa, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [31:0] rdata,
                       input int ad, input int dd, input int stall, input bit from_done);
        bit mem;
        cyc(1, 0, 0, 1, 0, 1, 0, from_done);
        issue(op, addr, st, we, wa, alu, pc, rdata, mem);
        if (mem) begin
            for (int i = 0; i <= ad; i++) cyc(0, i == ad, (i == ad) && (dd == 0), 1, 0, 0, 1, 0);
            for (int j = 1; j <= dd; j++) cyc(0, 0, j == dd, 1, 0, 0, 0, 0);
        end
        for (int k = 0; k < stall; k++) cyc(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic release_done();
        cyc(0, 0, 0, 1, 0, 1, 0, 1);
    endtask
    task automatic idle();
        cyc(0, 0, 0, 1, 0, 1, 0, 0);
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1;
        reset = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; ds_valid = 1'b0; flush = 1'b0;
        p_pc = 32'h1c000000; p_we = 32'd0; p_wa = 32'd0; p_rf = 32'd0;
        exp_pc = p_pc; exp_we = 0; exp_wa = 0; exp_rf = 0;
        exp_rst = 1'b1; exp_valid = 1'b0; exp_req = 1'b0; exp_allow = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        exp_rst = 1'b0;
    endtask

    bit m;

    initial begin
        reset = 1'b0; flush = 1'b0; ds_valid = 1'b0; ds_pc = 0; ds_mem_op = 0; ds_addr = 0;
        ds_st_data = 0; ds_rf_we = 0; ds_rf_waddr = 0; ds_rf_wdata = 0;
        data_sram_addr_ok = 0; data_sram_data_ok = 0; data_sram_rdata = 0; wb_allow_in = 1'b1;
        exp_addr = 0; exp_strb = 0; exp_wd = 0; exp_chk_wd = 0;
        p_pc = 32'h1c000000; p_we = 0; p_wa = 0; p_rf = 0;
        exp_pc = p_pc; exp_we = 0; exp_wa = 0; exp_rf = 0;
        exp_rst = 1'b1; exp_valid = 1'b0; exp_req = 1'b0; exp_allow = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
        p_ale = 1'b0; exp_ale = 1'b0;
`endif
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        exp_rst = 1'b0;

        chk("pin_stb_strb", m_strb(4'd4, 32'h00001003), 32'h8);
        chk("pin_stb_wdata", m_wdata(4'd4, 32'h000000a5), 32'ha5a5a5a5);
        chk("pin_ldb", m_load(4'd1, 32'h2, 32'h00800000), 32'hffffff80);
        chk("pin_ldbu", m_load(4'd9, 32'h2, 32'h00800000), 32'h00000080);
        chk("pin_ldh", m_load(4'd2, 32'h2, 32'h80010000), 32'hffff8001);
        chk("pin_sth_strb", m_strb(4'd5, 32'h2), 32'hc);

        // st.b byte 3, same-cycle addr_ok/data_ok
        run(4'd4, 32'h00001003, 32'h000000a5, 4'hf, 5'd3, 32'h11, 32'h1c000010, 0, 0, 0, 0, 0);
        release_done(); idle();
        run(4'd1, 32'h00002002, 0, 4'hf, 5'd4, 32'h22, 32'h1c000014, 32'h00800000, 0, 1, 0, 0);
        release_done();
        run(4'd9, 32'h00002002, 0, 4'hf, 5'd5, 32'h33, 32'h1c000018, 32'h00800000, 1, 0, 0, 0);
        release_done(); idle();
        run(4'd3, 32'h00003000, 0, 4'hf, 5'd6, 32'h44, 32'h1c00001c, 32'h12345678, 3, 2, 0, 0);
        release_done();
        run(4'd2, 32'h00003002, 0, 4'h3, 5'd7, 0, 32'h1c000020, 32'h80010000, 0, 1, 0, 0);
        release_done();
        run(4'd10, 32'h00003000, 0, 4'h1, 5'd8, 0, 32'h1c000024, 32'h0000f00f, 1, 1, 0, 0);
        release_done();
        run(4'd5, 32'h00004002, 32'h1234beef, 4'hf, 5'd9, 32'h55, 32'h1c000028, 0, 0, 1, 0, 0);
        release_done();
        run(4'd6, 32'h00004008, 32'hcafef00d, 4'hf, 5'd10, 32'h66, 32'h1c00002c, 0, 2, 0, 0, 0);
        release_done(); idle();
        // back-to-back: ALU op, unknown op, then load, each accepted in the prior DONE cycle
        run(4'd0, 32'h0, 0, 4'ha, 5'd11, 32'hdeadbeef, 32'h1c000030, 0, 0, 0, 0, 0);
        run(4'd7, 32'h5, 32'hffffffff, 4'h5, 5'd12, 32'h01234567, 32'h1c000034, 0, 0, 0, 0, 1);
        run(4'd1, 32'h00005001, 0, 4'hf, 5'd13, 0, 32'h1c000038, 32'h00007f00, 0, 0, 0, 1);
        release_done();
        // WB stalls 3 cycles
        run(4'd3, 32'h00006000, 0, 4'hf, 5'd14, 0, 32'h1c00003c, 32'h89abcdef, 1, 1, 3, 0);
        release_done(); idle();

        // flush in REQ
        cyc(1, 0, 0, 1, 0, 1, 0, 0);
        issue(4'd3, 32'h00007000, 0, 4'hf, 5'd15, 0, 32'h1c000040, 32'h0, m);
        cyc(0, 0, 0, 1, 1, 0, 1, 0);
        idle(); idle();
        // flush in WAIT, data_ok two cycles later is swallowed
        cyc(1, 0, 0, 1, 0, 1, 0, 0);
        issue(4'd3, 32'h00007004, 0, 4'hf, 5'd16, 0, 32'h1c000044, 32'h5a5a5a5a, m);
        cyc(0, 1, 0, 1, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 0, 0);
        idle(); idle();
        // flush in DONE
        run(4'd0, 32'h0, 0, 4'hf, 5'd17, 32'h77, 32'h1c000048, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 1);
        idle();

`ifdef MEM_ALIGN_CHECK_EN
        run(4'd3, 32'h00008002, 0, 4'hf, 5'd18, 32'h88, 32'h1c00004c, 0, 0, 0, 0, 0);
        release_done(); idle();
`endif

        // reset in WAIT abandons the load
        cyc(1, 0, 0, 1, 0, 1, 0, 0);
        issue(4'd3, 32'h00009000, 0, 4'hf, 5'd19, 0, 32'h1c000050, 32'h0, m);
        cyc(0, 1, 0, 1, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        reset_pulse();
        idle(); idle();
        run(4'd9, 32'h0000a003, 0, 4'hf, 5'd20, 0, 32'h1c000054, 32'hfe000000, 0, 0, 0, 0);
        release_done(); idle();

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
